// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: synchronizer, priming, step/dir, wrapping count, sticky error.
// Optional per-phase glitch filter enabled by defining QUAD_DEBOUNCE_EN.
module quad_decoder #(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             a_in,
  input  logic             b_in,
  output logic             step,
  output logic             dir,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             err
);

`ifdef QUAD_DEBOUNCE_EN
  localparam int PRIME = SYNC_STAGES + 1 + FILTER_CYCLES;
`else
  localparam int PRIME = SYNC_STAGES + 1;
`endif
  localparam int PW = $clog2(PRIME + 1);

  logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
  logic [1:0]             synced;
  logic [1:0]             ph;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a_in};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], b_in};
    end
  end

  assign synced = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

`ifdef QUAD_DEBOUNCE_EN
  localparam int FW = (FILTER_CYCLES > 2) ? $clog2(FILTER_CYCLES) : 1;

  logic [1:0]    filt_q;
  logic [FW-1:0] fcnt_q [2];

  // A phase follows the synced level only after FILTER_CYCLES disagreeing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= '0;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (synced[i] != filt_q[i]) begin
          if (fcnt_q[i] == FW'(FILTER_CYCLES - 1)) begin
            filt_q[i] <= synced[i];
            fcnt_q[i] <= '0;
          end else begin
            fcnt_q[i] <= fcnt_q[i] + FW'(1);
          end
        end else begin
          fcnt_q[i] <= '0;
        end
      end
    end
  end

  assign ph = filt_q;
`else
  assign ph = synced;
`endif

  logic [1:0]       prev_q, prev_d;
  logic [PW-1:0]    prime_q, prime_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [1:0]       up_nb, dn_nb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q  <= '0;
      prime_q <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b1;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      prev_q  <= prev_d;
      prime_q <= prime_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    up_nb   = {prev_q[0], ~prev_q[1]};
    dn_nb   = {~prev_q[0], prev_q[1]};
    prev_d  = ph;
    prime_d = prime_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    dir_d   = dir_q;
    err_d   = err_q;
    count_d = count_q;
    if (prime_q != PW'(PRIME)) begin
      prime_d = prime_q + PW'(1);
    end else begin
      unique case (1'b1)
        (ph == prev_q): begin
        end
        (ph == up_nb): begin
          step_d  = 1'b1;
          dir_d   = 1'b1;
          wrap_d  = (count_q == '1);
          count_d = count_q + WIDTH'(1);
        end
        (ph == dn_nb): begin
          step_d  = 1'b1;
          dir_d   = 1'b0;
          wrap_d  = (count_q == '0);
          count_d = count_q - WIDTH'(1);
        end
        default: err_d = 1'b1;
      endcase
    end
    if (clear) begin
      count_d = '0;
      err_d   = 1'b0;
      wrap_d  = 1'b0;
    end
  end

  assign step  = step_q;
  assign dir   = dir_q;
  assign wrap  = wrap_q;
  assign err   = err_q;
  assign count = count_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed and random quadrature sequences against a position-index reference model.
module tb_quad_decoder;
  localparam int W  = 4;
  localparam int SS = 2;
`ifdef QUAD_DEBOUNCE_EN
  localparam int FC = 4;
`else
  localparam int FC = 0;
`endif
  localparam int LAT   = SS + FC;
  localparam int HOLD  = LAT + 2;
  localparam int PRIME = SS + 1 + FC;
  localparam int MOD   = 1 << W;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         clear = 1'b0;
  logic         a_in = 1'b0;
  logic         b_in = 1'b0;
  logic         step, dir, wrap, err;
  logic [W-1:0] count;

  quad_decoder #(.WIDTH(W), .SYNC_STAGES(SS), .FILTER_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .a_in(a_in), .b_in(b_in),
    .step(step), .dir(dir), .count(count),
    .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [1:0] m_prev;
  int         m_cnt;
  logic       m_dir;
  logic       m_err;

  // Gray position of a phase pair along the up direction
  function automatic int pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] at_pos(input int p);
    logic [1:0] g [4];
    g = '{2'b00, 2'b01, 2'b11, 2'b10};
    return g[p % 4];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic move(input logic [1:0] ab, input bit clr);
    int d;
    bit es, ew;
    d  = (pos(ab) - pos(m_prev) + 4) % 4;
    es = 1'b0;
    ew = 1'b0;
    case (d)
      1: begin
        es = 1'b1; m_dir = 1'b1;
        ew = (m_cnt == MOD - 1);
        m_cnt = (m_cnt + 1) % MOD;
      end
      3: begin
        es = 1'b1; m_dir = 1'b0;
        ew = (m_cnt == 0);
        m_cnt = (m_cnt + MOD - 1) % MOD;
      end
      2: m_err = 1'b1;
      default: ;
    endcase
    m_prev = ab;
    if (clr) begin
      m_cnt = 0; m_err = 1'b0; ew = 1'b0;
    end
    @(negedge clk);
    a_in = ab[1];
    b_in = ab[0];
    for (int k = 0; k < HOLD; k++) begin
      @(posedge clk);
      #1;
      chk("step", 32'(step), (k == LAT) ? 32'(es) : 32'd0);
      chk("wrap", 32'(wrap), (k == LAT) ? 32'(ew) : 32'd0);
      if (clr && k == LAT - 1) clear = 1'b1;
      if (k == LAT) clear = 1'b0;
    end
    chk("count", 32'(count), 32'(m_cnt));
    chk("dir", 32'(dir), 32'(m_dir));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic reset_outputs_chk();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dir", 32'(dir), 32'd1);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
  endtask

  task automatic do_reset(input logic [1:0] ab);
    @(negedge clk);
    reset_n = 1'b0;
    a_in = ab[1];
    b_in = ab[0];
    #1;
    reset_outputs_chk();
    @(negedge clk);
    reset_n = 1'b1;
    m_prev = ab; m_cnt = 0; m_dir = 1'b1; m_err = 1'b0;
    for (int k = 0; k < PRIME + 3; k++) begin
      @(posedge clk);
      #1;
      chk("prime_step", 32'(step), 32'd0);
      chk("prime_err", 32'(err), 32'd0);
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    m_cnt = 0; m_err = 1'b0;
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_wrap", 32'(wrap), 32'd0);
  endtask

  initial begin
    do_reset(2'b00);
    // forward rotation
    move(2'b01, 0); move(2'b11, 0); move(2'b10, 0); move(2'b00, 0);
    pulse_clear();
    // reverse rotation through zero
    move(2'b10, 0); move(2'b11, 0); move(2'b01, 0); move(2'b00, 0);
    // illegal double change, then clear
    move(2'b11, 0);
    pulse_clear();
    // clear coinciding with a valid step
    move(2'b10, 1);
    move(2'b00, 0);
    // clear coinciding with an illegal change
    move(2'b11, 1);
    // start at rest on a non-zero state
    do_reset(2'b11);
    move(2'b10, 0);
`ifdef QUAD_DEBOUNCE_EN
    move(2'b00, 0);
    @(negedge clk);
    a_in = 1'b1;
    repeat (2) @(negedge clk);
    a_in = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      chk("glitch_step", 32'(step), 32'd0);
    end
    move(2'b10, 0);
`endif
    for (int i = 0; i < 60; i++) begin
      logic [1:0] ab;
      bit c;
      ab = 2'($urandom_range(0, 3));
      c  = ($urandom_range(0, 9) == 0);
      move(ab, c);
    end
    // reset between edges once count reaches 7
    pulse_clear();
    while (m_cnt != 7) move(at_pos(pos(m_prev) + 1), 0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    reset_outputs_chk();
    do_reset({a_in, b_in});
    move(at_pos(pos(m_prev) + 3), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
